prog_counter: RTL and testbench
===============================

// Module: prog_counter
// PURPOSE
//  Parametrised up/down modulo counter with a runtime-programmable limit,
//  parallel load, enable, wrap/saturate mode and registered terminal-count pulse.
//  Generalises the fixed-modulus free-running counter. Drives the LED cube's
//  frame, layer and PWM-slot sequencing, where the modulus changes at run time.
// PARAMETERS
//  N          8    counter/limit width in bits (N >= 2)
//  MAX_COUNT  255  reset value of limit register; must be <= 2^N-1
//  PRESCALE   4    enabled cycles per step; used only with PROG_COUNTER_PRESCALE_EN
// PORTS
//  clk         in   1  clock; all state updates on rising edge
//  reset       in   1  synchronous, active-high reset
//  en          in   1  step request for this cycle
//  up          in   1  1 = count up, 0 = count down (sampled with en)
//  load        in   1  parallel load request
//  load_value  in   N  value for load
//  limit_we    in   1  write limit register
//  limit_in    in   N  new limit (range is 0..limit inclusive)
//  saturate    in   1  1 = hold at boundary, 0 = wrap
//  count       out  N  registered count value
//  tc          out  1  registered terminal-count pulse, 1 cycle
//  limit       out  N  current limit register value
// BEHAVIOUR
//  - Reset (sync, active-high): count=0, tc=0, limit=MAX_COUNT, prescaler=0.
//    Reset overrides every other input in the same cycle.
//  - Priority per cycle: reset > load > step. limit_we is independent of
//    load/step and is written in parallel.
//  - Comparisons in a cycle use the limit value from before that cycle's write.
//  - The new limit applies from the next cycle.
//  - Latency: count reflects load/step on the edge that samples the request.
//  - Load: count <= min(load_value, limit). tc=0. Prescaler cleared.
//  - Step up: if count < limit, count+1. Otherwise (count >= limit):
//    - wrap mode: count <= 0, tc <= 1.
//    - saturate mode: count <= limit, tc <= 1.
//  - Step down: if count > limit, count <= limit, tc <= 0.
//    Otherwise, if count > 0, count-1.
//    Otherwise (count == 0):
//    - wrap mode: count <= limit, tc <= 1.
//    - saturate mode: count <= 0, tc <= 1.
//  - tc is high only in the cycle after a boundary step, and low in every other
//    cycle. With saturate mode, tc pulses on each step attempted at the boundary.
//  - limit == 0: count stays 0 and every step pulses tc.
//  - No N-bit overflow: the boundary compare precedes increment/decrement.
//  - No en: count holds, tc=0. up and saturate are don't-care without en or load.
// CONFIGURATION
//  PROG_COUNTER_PRESCALE_EN defined:
//  - Internal prescaler of width clog2(PRESCALE) counts en cycles 0..PRESCALE-1.
//  - A step occurs only on the en cycle where the prescaler equals PRESCALE-1;
//    the prescaler then returns to 0.
//  - Prescaler is cleared by reset and load. PRESCALE=1 behaves as undefined.
//  PROG_COUNTER_PRESCALE_EN undefined: every en cycle is a step; PRESCALE ignored.
// TESTING
//  1 reset=1 with en=1,load=1 -> next cycle count=0, tc=0, limit=MAX_COUNT (255).
//  2 limit=9, wrap, up, en held 12 cycles from 0 -> count 1..9,0,1,2;
//    tc high only the cycle count becomes 0.
//  3 limit=9, saturate, down, en from 2 -> 1,0,0,0;
//    tc high in both cycles with count held 0 after reaching 0.
//  4 count=200, limit_we with limit_in=50, up step same cycle -> count=201,
//    limit=50; next step -> count=0, tc=1.
//  5 load_value=77 with limit=40, load and en same cycle -> count=40, tc=0;
//    load wins over step.
//  6 PRESCALE_EN with PRESCALE=4, en held 8 cycles from 0, up ->
//    count steps to 1 on 4th and 2 on 8th en cycle.

Source files
------------

// File: rtl/prog_counter.sv
// ---------------------------------------------------------------------------
// prog_counter
//   Up/down modulo counter with a runtime-programmable limit, parallel load,
//   enable, wrap/saturate boundary mode and a registered terminal-count pulse.
//   The count range is 0..limit inclusive.
//
//   Optional feature macro: PROG_COUNTER_PRESCALE_EN
//     When defined, only every PRESCALE-th enabled cycle performs a step.
//     When undefined, every enabled cycle is a step and PRESCALE is ignored.
// ---------------------------------------------------------------------------
module prog_counter #(
   parameter int N         = 8,
   parameter int MAX_COUNT = 255,
   parameter int PRESCALE  = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         up,
   input  logic         load,
   input  logic [N-1:0] load_value,
   input  logic         limit_we,
   input  logic [N-1:0] limit_in,
   input  logic         saturate,
   output logic [N-1:0] count,
   output logic         tc,
   output logic [N-1:0] limit
);

   localparam logic [N-1:0] ONE = N'(1);

   // Reject parameter sets the counter cannot honour at elaboration time.
   if (N < 2 || PRESCALE < 1 || MAX_COUNT < 0 || MAX_COUNT > (2**N - 1)) begin : g_bad_params
      $error("prog_counter: illegal parameter combination");
   end

   logic [N-1:0] count_reg;
   logic [N-1:0] count_next;
   logic         tc_reg;
   logic         tc_next;
   logic [N-1:0] limit_reg;
   logic         step;

`ifdef PROG_COUNTER_PRESCALE_EN
   // Prescaler width is at least one bit so PRESCALE=1 still elaborates;
   // with PRESCALE=1 the terminal value is 0 and every en cycle steps.
   localparam int           PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pre_reg;

   assign step = en && (pre_reg == PRE_LAST);

   // Prescaler: counts enabled cycles, restarts after each step or on load.
   always_ff @(posedge clk) begin
      if (reset) begin
         pre_reg <= '0;
      end else if (load) begin
         pre_reg <= '0;
      end else if (en) begin
         pre_reg <= step ? '0 : pre_reg + PW'(1);
      end
   end
`else
   assign step = en;
`endif

   // Next-state decision: load beats step; boundary compare happens before
   // any increment/decrement so the N-bit value never overflows.
   always_comb begin
      count_next = count_reg;
      tc_next    = 1'b0;
      if (load) begin
         count_next = (load_value > limit_reg) ? limit_reg : load_value;
      end else if (step) begin
         if (up) begin
            if (count_reg < limit_reg) begin
               count_next = count_reg + ONE;
            end else begin
               count_next = saturate ? limit_reg : '0;
               tc_next    = 1'b1;
            end
         end else begin
            if (count_reg > limit_reg) begin
               // Limit was lowered below the count: snap to the new top.
               count_next = limit_reg;
            end else if (count_reg != '0) begin
               count_next = count_reg - ONE;
            end else begin
               count_next = saturate ? '0 : limit_reg;
               tc_next    = 1'b1;
            end
         end
      end
   end

   // Count and terminal-count registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= '0;
         tc_reg    <= 1'b0;
      end else begin
         count_reg <= count_next;
         tc_reg    <= tc_next;
      end
   end

   // Limit register: written in parallel with load/step; the write only
   // takes effect for comparisons from the following cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         limit_reg <= N'(MAX_COUNT);
      end else if (limit_we) begin
         limit_reg <= limit_in;
      end
   end

   assign count = count_reg;
   assign tc    = tc_reg;
   assign limit = limit_reg;

endmodule

// File: tb/tb_prog_counter.sv
// ---------------------------------------------------------------------------
// tb_prog_counter
//   Directed scenarios plus randomized traffic for prog_counter, checked
//   cycle by cycle against an integer reference model of the counter rules.
//   Honors PROG_COUNTER_PRESCALE_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_prog_counter;

   localparam int N    = 8;
   localparam int MAXC = 255;
   localparam int PS   = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         en;
   logic         up;
   logic         load;
   logic [N-1:0] load_value;
   logic         limit_we;
   logic [N-1:0] limit_in;
   logic         saturate;
   logic [N-1:0] count;
   logic         tc;
   logic [N-1:0] limit;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_count = 0;
   int m_tc    = 0;
   int m_limit = MAXC;
   int m_pre   = 0;

   prog_counter #(.N(N), .MAX_COUNT(MAXC), .PRESCALE(PS)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .up         (up),
      .load       (load),
      .load_value (load_value),
      .limit_we   (limit_we),
      .limit_in   (limit_in),
      .saturate   (saturate),
      .count      (count),
      .tc         (tc),
      .limit      (limit)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      reset      = 1'b0;
      en         = 1'b0;
      up         = 1'b0;
      load       = 1'b0;
      load_value = '0;
      limit_we   = 1'b0;
      limit_in   = '0;
      saturate   = 1'b0;
   endtask

   // Apply the counter rules to the current inputs and model state.
   task automatic model_update();
      int  nc;
      int  ntc;
      int  nl;
      int  np;
      bit  stp;
      nc  = m_count;
      ntc = 0;
      nl  = m_limit;
      np  = m_pre;
      stp = 1'b0;
      if (reset) begin
         nc = 0;
         nl = MAXC;
         np = 0;
      end else begin
         if (limit_we) nl = int'(limit_in);
         if (load) begin
            nc = (int'(load_value) < m_limit) ? int'(load_value) : m_limit;
            np = 0;
         end else if (en) begin
`ifdef PROG_COUNTER_PRESCALE_EN
            if (m_pre == PS - 1) begin
               stp = 1'b1;
               np  = 0;
            end else begin
               np  = m_pre + 1;
            end
`else
            stp = 1'b1;
`endif
            if (stp) begin
               if (up) begin
                  if (m_count < m_limit) nc = m_count + 1;
                  else begin
                     nc  = saturate ? m_limit : 0;
                     ntc = 1;
                  end
               end else begin
                  if (m_count > m_limit) nc = m_limit;
                  else if (m_count > 0) nc = m_count - 1;
                  else begin
                     nc  = saturate ? 0 : m_limit;
                     ntc = 1;
                  end
               end
            end
         end
      end
      m_count = nc;
      m_tc    = ntc;
      m_limit = nl;
      m_pre   = np;
   endtask

   // One clock with the currently driven inputs; compare DUT to model after the edge.
   task automatic tick(input string tag);
      model_update();
      @(posedge clk);
      #1;
      $display("%0t %s en=%0b up=%0b ld=%0b sat=%0b lwe=%0b -> count=%0d tc=%0b limit=%0d",
               $time, tag, en, up, load, saturate, limit_we, count, tc, limit);
      check({tag, "_count"}, 32'(count), 32'(m_count));
      check({tag, "_tc"},    32'(tc),    32'(m_tc));
      check({tag, "_limit"}, 32'(limit), 32'(m_limit));
   endtask

   initial begin
      int e2[12];
      int e3[4];
      int t3[4];
      e2 = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
      e3 = '{1, 0, 0, 0};
      t3 = '{0, 0, 1, 1};

      idle_inputs();

      // 1: reset overrides en/load/limit_we
      reset = 1'b1; en = 1'b1; load = 1'b1; load_value = 8'd5;
      limit_we = 1'b1; limit_in = 8'd3;
      tick("t1_reset");
      check("t1_count_zero", 32'(count), 32'd0);
      check("t1_tc_zero", 32'(tc), 32'd0);
      check("t1_limit_max", 32'(limit), 32'd255);
      idle_inputs();

      // 2: limit 9, wrap, count up from 0
      limit_we = 1'b1; limit_in = 8'd9; load = 1'b1; load_value = 8'd0;
      tick("t2_setup");
      idle_inputs();
      en = 1'b1; up = 1'b1; saturate = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick("t2_step");
`ifndef PROG_COUNTER_PRESCALE_EN
         check("t2_seq_count", 32'(count), 32'(e2[i]));
         check("t2_seq_tc", 32'(tc), (i == 9) ? 32'd1 : 32'd0);
`endif
      end
      idle_inputs();

      // 3: saturate down from 2
      load = 1'b1; load_value = 8'd2;
      tick("t3_setup");
      idle_inputs();
      en = 1'b1; up = 1'b0; saturate = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick("t3_step");
`ifndef PROG_COUNTER_PRESCALE_EN
         check("t3_seq_count", 32'(count), 32'(e3[i]));
         check("t3_seq_tc", 32'(tc), 32'(t3[i]));
`endif
      end
      idle_inputs();

      // 4: limit lowered below count in the same cycle as an up step
      limit_we = 1'b1; limit_in = 8'd255;
      tick("t4_lim");
      idle_inputs();
      load = 1'b1; load_value = 8'd200;
      tick("t4_load");
      idle_inputs();
      en = 1'b1; up = 1'b1; limit_we = 1'b1; limit_in = 8'd50;
      tick("t4_step1");
`ifndef PROG_COUNTER_PRESCALE_EN
      check("t4_count_201", 32'(count), 32'd201);
      check("t4_limit_50", 32'(limit), 32'd50);
`endif
      limit_we = 1'b0;
      tick("t4_step2");
`ifndef PROG_COUNTER_PRESCALE_EN
      check("t4_count_wrap", 32'(count), 32'd0);
      check("t4_tc_wrap", 32'(tc), 32'd1);
`endif
      idle_inputs();

      // 5: load clamps to limit and wins over step
      limit_we = 1'b1; limit_in = 8'd40;
      tick("t5_lim");
      idle_inputs();
      load = 1'b1; load_value = 8'd77; en = 1'b1; up = 1'b1;
      tick("t5_load");
      check("t5_count_clamp", 32'(count), 32'd40);
      check("t5_tc_low", 32'(tc), 32'd0);
      idle_inputs();

`ifdef PROG_COUNTER_PRESCALE_EN
      // 6: prescaled stepping, one step per PS enabled cycles
      limit_we = 1'b1; limit_in = 8'd9; load = 1'b1; load_value = 8'd0;
      tick("t6_setup");
      idle_inputs();
      en = 1'b1; up = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick("t6_step");
         check("t6_seq_count", 32'(count), 32'(i / PS));
      end
      idle_inputs();
`endif

      // Randomized traffic, small limits most of the time to hit boundaries
      for (int i = 0; i < 3000; i++) begin
         reset      = ($urandom_range(0, 199) == 0);
         load       = ($urandom_range(0, 99) < 8);
         load_value = ($urandom_range(0, 1) == 0) ? N'($urandom_range(0, 255))
                                                  : N'($urandom_range(0, 14));
         limit_we   = ($urandom_range(0, 99) < 5);
         limit_in   = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 255))
                                                  : N'($urandom_range(0, 12));
         en         = ($urandom_range(0, 99) < 75);
         up         = 1'($urandom_range(0, 1));
         saturate   = 1'($urandom_range(0, 1));
         tick("rnd");
      end
      idle_inputs();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
